// File: rtl/sd_sector_fetch_ctrl.sv
// Double-buffered SD sector fetcher: reads 512-byte sectors byte-by-byte from a backing store.
// Optional define SD_FETCH_PREFETCH_EN starts the next sector as soon as the idle bank is free.
module sd_sector_fetch_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_req,
    input  logic [31:0] sec_no,
    input  logic        sec_cont,
    input  logic        sec_stop,
    input  logic [8:0]  rd_idx,
    output logic [7:0]  rd_data,
    input  logic        rd_done,
    output logic        buf_ready,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

`ifdef SD_FETCH_PREFETCH_EN
    localparam logic PrefetchEn = 1'b1;
`else
    localparam logic PrefetchEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     sector_q, sector_d;
    logic            cont_q, cont_d;
    logic [1:0]      valid_q, valid_d;
    logic            cur_bank_q, cur_bank_d;
    logic            fill_bank_q, fill_bank_d;
    logic [8:0]      offset_q, offset_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      rd_data_q;
    logic            bank_we;
    logic            timeout_hit;
    logic            hold_fetch;
    logic [7:0]      bank_mem [1024];

    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        cont_d      = cont_q;
        valid_d     = valid_q;
        cur_bank_d  = cur_bank_q;
        fill_bank_d = fill_bank_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        bank_we     = 1'b0;
        timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
        // Without prefetch, refill only once the consumer has released every bank.
        hold_fetch  = cont_q && !valid_q[fill_bank_q] && (PrefetchEn || !valid_q[cur_bank_q]);

        if (rd_done && valid_q[cur_bank_q]) begin
            valid_d[cur_bank_q] = 1'b0;
            cur_bank_d          = ~cur_bank_q;
        end

        unique case (state_q)
            StIdle: begin
                if (sec_stop) begin
                    valid_d = '0;
                end else if (sec_req) begin
                    sector_d    = sec_no;
                    cont_d      = sec_cont;
                    valid_d     = '0;
                    cur_bank_d  = 1'b0;
                    fill_bank_d = 1'b0;
                    offset_d    = '0;
                    err_d       = 1'b0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (sec_stop) begin
                    valid_d = '0;
                    state_d = StIdle;
                end else if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sec_stop) begin
                    valid_d = '0;
                    cnt_d   = '0;
                    state_d = StDrain;
                end else if (mem_rvalid) begin
                    bank_we  = 1'b1;
                    offset_d = offset_q + 9'd1;
                    state_d  = StReq;
                    if (offset_q == 9'h1FF) begin
                        valid_d[fill_bank_q] = 1'b1;
                        sector_d             = sector_q + 32'd1;
                        fill_bank_d          = ~fill_bank_q;
                        if (!(PrefetchEn && cont_q && !valid_d[~fill_bank_q])) begin
                            state_d = StHold;
                        end
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    valid_d = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (sec_stop) begin
                    valid_d = '0;
                    state_d = StIdle;
                end else if (hold_fetch) begin
                    state_d = StReq;
                end else if (!cont_q && !valid_q[cur_bank_q]) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sector_q    <= '0;
            cont_q      <= 1'b0;
            valid_q     <= '0;
            cur_bank_q  <= 1'b0;
            fill_bank_q <= 1'b0;
            offset_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sector_q    <= sector_d;
            cont_q      <= cont_d;
            valid_q     <= valid_d;
            cur_bank_q  <= cur_bank_d;
            fill_bank_q <= fill_bank_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Bank storage is not reset; valid bits guard its contents.
    always_ff @(posedge clk) begin
        if (bank_we) begin
            bank_mem[{fill_bank_q, offset_q}] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bank_mem[{cur_bank_q, rd_idx}];
        end
    end

    assign rd_data   = rd_data_q;
    assign buf_ready = valid_q[cur_bank_q];
    assign mem_req   = (state_q == StReq);
    assign mem_addr  = mem_req ? {23'h0, sector_q, offset_q} : 64'h0;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

endmodule

// File: doc/sd_sector_fetch_ctrl.md
SD_SECTOR_FETCH_CTRL -- requirements
Module: sd_sector_fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max cycles from mem_gnt to mem_rvalid before error.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port sec_req  in  1  one-cycle pulse, start fetch of sector sec_no.
REQ-005 SHALL have port sec_no  in  32  sector number, sampled on sec_req.
REQ-006 SHALL have port sec_cont  in  1  multi-block mode, sampled on sec_req.
REQ-007 SHALL have port sec_stop  in  1  pulse, abort all fetching.
REQ-008 SHALL have port rd_idx  in  9  byte index within current bank.
REQ-009 SHALL have port rd_data  out  8  bank byte, registered, valid 1 cycle after rd_idx.
REQ-010 SHALL have port rd_done  in  1  pulse, consumer finished current bank.
REQ-011 SHALL have port buf_ready  out  1  current bank holds a complete sector.
REQ-012 SHALL have ports mem_req out 1, mem_addr out 64 (byte address), mem_gnt in 1, mem_rvalid in 1, mem_rdata in 8: backing-store byte read port.
REQ-013 SHALL have ports busy out 1 (state != IDLE) and err out 1 (sticky timeout flag).

Function
REQ-014 SHALL hold two 512-byte banks; cur_bank selects read bank, fill_bank selects write bank.
REQ-015 SHALL implement states IDLE, REQ, WAIT, HOLD, DRAIN.
REQ-016 IDLE + sec_req: latch sector=sec_no, cont=sec_cont, clear both valid bits, cur_bank=fill_bank=0, offset=0, err=0, go REQ.
REQ-017 REQ: mem_req=1, mem_addr={23'h0,sector,offset}; stable until mem_gnt=1 sampled, then go WAIT.
REQ-018 WAIT: mem_req=0; on mem_rvalid write mem_rdata to bank[fill_bank][offset], offset+1 mod 512, go REQ unless offset was 511.
REQ-019 Offset 511 rvalid: set valid[fill_bank], sector+1 (32-bit wrap), toggle fill_bank; if cont and PREFETCH_EN and new fill_bank not valid go REQ, else go HOLD.
REQ-020 HOLD: if cont and valid[fill_bank]=0 and fill_bank!=cur_bank-with-valid go REQ; if cont=0 and valid[cur_bank]=0 go IDLE.
REQ-021 rd_done with buf_ready=1: clear valid[cur_bank], toggle cur_bank same cycle; rd_done with buf_ready=0 ignored.
REQ-022 buf_ready = valid[cur_bank], combinational from registered state.
REQ-023 At most one memory transaction outstanding; no mem_req while in WAIT.
REQ-024 WAIT counter: reset on entry; reaching TIMEOUT without mem_rvalid sets err=1, clears valid bits, go IDLE.
REQ-025 sec_stop in REQ/HOLD/IDLE: go IDLE next cycle, clear valid bits, mem_req=0.
REQ-026 sec_stop in WAIT: go DRAIN; DRAIN discards data, exits to IDLE on mem_rvalid or timeout (err not set).
REQ-027 sec_stop and sec_req same cycle: stop wins, sec_req dropped; sec_req outside IDLE ignored.
REQ-028 rd_data reads bank[cur_bank][rd_idx] every cycle regardless of buf_ready.

Reset
REQ-029 rst=1 SHALL force IDLE, mem_req=0, mem_addr=0, buf_ready=0, busy=0, err=0, rd_data=0, both valid=0, cur_bank=fill_bank=0, offset=0, counter=0.
REQ-030 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset SHALL be ignored in IDLE.
REQ-031 Bank RAM contents SHALL NOT require reset.

Configuration
REQ-032 Macro SD_FETCH_PREFETCH_EN defined: in cont mode, fetch of sector N+1 into the idle bank starts immediately after sector N completes.
REQ-033 SD_FETCH_PREFETCH_EN undefined: next sector fetch starts only from HOLD after rd_done frees a bank; single-block behaviour identical.

Verification
REQ-034 sec_req sec_no=5 cont=0, memory returns byte=addr[7:0] in 2 cycles -> mem_addr 0xA00..0xBFF in order, buf_ready=1, rd_idx=3 gives rd_data=0x03 next cycle.
REQ-035 cont=1 sec_no=0xFFFFFFFF with PREFETCH_EN -> second fetch addresses 0x0..0x1FF (sector wrap) before rd_done; rd_done -> buf_ready stays 1.
REQ-036 Same as REQ-035 without PREFETCH_EN -> no mem_req after first sector until rd_done, then fetch of sector 0.
REQ-037 TIMEOUT=16, mem_rvalid never asserted -> err=1 at 16 cycles after gnt, busy=0, buf_ready=0.
REQ-038 sec_stop during WAIT of byte 100, rvalid 3 cycles later -> DRAIN then IDLE, no valid bank, err=0; sec_req+sec_stop same cycle -> stays IDLE.
REQ-039 rst pulse at byte 300 of fetch -> all outputs at reset values next cycle, stray rvalid ignored.
